// File: rtl/branch_predict_unit.sv
// Branch resolve and fetch predictor: resolves JAL/JALR/conditional branches
// from raw operands. A direct-mapped BTB with 2-bit counters is trained at
// resolve time. Mispredicts are flagged with a redirect PC, and control-flow
// and mispredict statistics are kept.
module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [XLEN-1:0]  i_if_pc,
  output logic             o_pred_taken,
  output logic [XLEN-1:0]  o_pred_target,
  input  logic             i_ex_valid,
  input  logic [6:0]       i_ex_opcode,
  input  logic [2:0]       i_ex_funct3,
  input  logic [XLEN-1:0]  i_ex_pc,
  input  logic [XLEN-1:0]  i_ex_rs1,
  input  logic [XLEN-1:0]  i_ex_rs2,
  input  logic [XLEN-1:0]  i_ex_imm,
  input  logic             i_ex_pred_taken,
  input  logic [XLEN-1:0]  i_ex_pred_target,
  output logic             o_ex_taken,
  output logic [XLEN-1:0]  o_ex_target,
  output logic             o_mispredict,
  output logic [XLEN-1:0]  o_redirect_pc,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic             jump_q   [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;

  logic             is_jal, is_jalr, is_branch;
  logic             legal_ctrl, illegal, taken;
  logic [XLEN-1:0]  target, pc_plus_imm, jalr_sum;

  logic             wr_en;
  logic             wr_valid_d, wr_jump_d;
  logic [TAG_W-1:0] wr_tag_d;
  logic [XLEN-1:0]  wr_target_d;
  logic [1:0]       wr_ctr_d;

  // PC bits below the word offset never take part in indexing or tagging
  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_if_pc[1:0], i_ex_pc[1:0]};

  assign if_idx = i_if_pc[IDX_W+1:2];
  assign if_tag = i_if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = i_ex_pc[IDX_W+1:2];
  assign ex_tag = i_ex_pc[XLEN-1:IDX_W+2];

  // Fetch-side lookup reads the pre-edge table, no bypass from resolve
  always_comb begin
    if_hit        = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    o_pred_taken  = if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);
    o_pred_target = o_pred_taken ? target_q[if_idx] : '0;
  end

  // Resolve: decode, compare, compute target and mispredict in one cycle
  always_comb begin
    is_jal      = i_ex_valid && (i_ex_opcode == OP_JAL);
    is_jalr     = i_ex_valid && (i_ex_opcode == OP_JALR);
    is_branch   = i_ex_valid && (i_ex_opcode == OP_BRANCH);
    pc_plus_imm = i_ex_pc + i_ex_imm;
    jalr_sum    = i_ex_rs1 + i_ex_imm;
    illegal     = 1'b0;
    taken       = 1'b0;
    target      = '0;
    if (is_jal) begin
      taken  = 1'b1;
      target = pc_plus_imm;
    end else if (is_jalr) begin
      if (i_ex_funct3 == 3'b000) begin
        taken  = 1'b1;
        target = {jalr_sum[XLEN-1:1], 1'b0};
      end else begin
        illegal = 1'b1;
      end
    end else if (is_branch) begin
      case (i_ex_funct3)
        3'b000:  taken = (i_ex_rs1 == i_ex_rs2);
        3'b001:  taken = (i_ex_rs1 != i_ex_rs2);
        3'b100:  taken = ($signed(i_ex_rs1) <  $signed(i_ex_rs2));
        3'b101:  taken = ($signed(i_ex_rs1) >= $signed(i_ex_rs2));
        3'b110:  taken = (i_ex_rs1 <  i_ex_rs2);
        3'b111:  taken = (i_ex_rs1 >= i_ex_rs2);
        default: illegal = 1'b1;
      endcase
      if (taken) target = pc_plus_imm;
    end
    legal_ctrl    = (is_jal || is_jalr || is_branch) && !illegal;
    o_ex_taken    = taken;
    o_ex_target   = target;
    o_illegal     = illegal;
    o_mispredict  = i_ex_valid && ((i_ex_pred_taken != taken) ||
                                   (taken && (i_ex_pred_target != target)));
    o_redirect_pc = !i_ex_valid ? '0 : (taken ? target : i_ex_pc + XLEN'(4));
  end

  // Next-state of the entry at the resolve index and of the statistics
  always_comb begin
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    wr_en       = 1'b0;
    wr_valid_d  = valid_q[ex_idx];
    wr_tag_d    = tag_q[ex_idx];
    wr_target_d = target_q[ex_idx];
    wr_jump_d   = jump_q[ex_idx];
    wr_ctr_d    = ctr_q[ex_idx];
    if (legal_ctrl) begin
      if (taken && ex_hit) begin
        wr_en       = 1'b1;
        wr_target_d = target;
        if (ctr_q[ex_idx] != 2'b11) wr_ctr_d = ctr_q[ex_idx] + 2'd1;
      end else if (taken) begin
        wr_en       = 1'b1;
        wr_valid_d  = 1'b1;
        wr_tag_d    = ex_tag;
        wr_target_d = target;
        wr_jump_d   = is_jal || is_jalr;
        wr_ctr_d    = (is_jal || is_jalr) ? 2'b11 : 2'b10;
      end else if (ex_hit) begin
        wr_en = 1'b1;
        if (ctr_q[ex_idx] != 2'b00) wr_ctr_d = ctr_q[ex_idx] - 2'd1;
      end
    end else if (i_ex_valid && i_ex_pred_taken && ex_hit) begin
      wr_en      = 1'b1;
      wr_valid_d = 1'b0;
    end
    branch_cnt_d  = branch_cnt_q + CNT_W'(legal_ctrl);
    mispred_cnt_d = mispred_cnt_q + CNT_W'(o_mispredict);
  end

  // Table and statistics registers; reset clears everything at once
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        jump_q[i]   <= 1'b0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (wr_en) begin
        valid_q[ex_idx]  <= wr_valid_d;
        tag_q[ex_idx]    <= wr_tag_d;
        target_q[ex_idx] <= wr_target_d;
        jump_q[ex_idx]   <= wr_jump_d;
        ctr_q[ex_idx]    <= wr_ctr_d;
      end
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed scoreboard bench for branch_predict_unit (XLEN=32, ENTRIES=64).
module tb_branch_predict_unit;

   localparam logic [6:0] OP_JAL = 7'h6F;
   localparam logic [6:0] OP_JALR = 7'h67;
   localparam logic [6:0] OP_BR = 7'h63;
   localparam logic [6:0] OP_ALU = 7'h13;

   logic clock = 1'b0;
   logic rstN;
   logic [31:0] ifPc;
   logic predTaken;
   logic [31:0] predTarget;
   logic exValid;
   logic [6:0] exOpcode;
   logic [2:0] exFunct3;
   logic [31:0] exPc, exRs1, exRs2, exImm;
   logic exPredTaken;
   logic [31:0] exPredTarget;
   logic exTaken;
   logic [31:0] exTarget;
   logic mispredict;
   logic [31:0] redirectPc;
   logic illegal;
   logic [31:0] branchCnt, mispredCnt;

   typedef struct {
      string name;
      logic predTaken;
      logic [31:0] predTarget;
      logic taken;
      logic [31:0] target;
      logic mispredict;
      logic [31:0] redirect;
      logic illegal;
      logic [31:0] branchCnt;
      logic [31:0] mispredCnt;
   } expect_t;

   expect_t expQ[$];
   int checks = 0;
   int errors = 0;

   // Free-running clock
   always #5 clock = ~clock;

   branch_predict_unit #(.XLEN(32), .ENTRIES(64), .CNT_W(32)) dut (
      .i_clk(clock),
      .i_rst_n(rstN),
      .i_if_pc(ifPc),
      .o_pred_taken(predTaken),
      .o_pred_target(predTarget),
      .i_ex_valid(exValid),
      .i_ex_opcode(exOpcode),
      .i_ex_funct3(exFunct3),
      .i_ex_pc(exPc),
      .i_ex_rs1(exRs1),
      .i_ex_rs2(exRs2),
      .i_ex_imm(exImm),
      .i_ex_pred_taken(exPredTaken),
      .i_ex_pred_target(exPredTarget),
      .o_ex_taken(exTaken),
      .o_ex_target(exTarget),
      .o_mispredict(mispredict),
      .o_redirect_pc(redirectPc),
      .o_illegal(illegal),
      .o_branch_cnt(branchCnt),
      .o_mispred_cnt(mispredCnt)
   );

   task automatic checkOutput(input string name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, exp);
      end
   endtask

   // Drives one cycle of inputs just after the rising edge and queues the expected response
   task automatic applyStimulus(input string name, input logic [31:0] lookPc, input logic valid,
                                input logic [6:0] op, input logic [2:0] f3,
                                input logic [31:0] pc, input logic [31:0] rs1,
                                input logic [31:0] rs2, input logic [31:0] imm,
                                input logic pt, input logic [31:0] ptgt,
                                input logic ePt, input logic [31:0] ePtgt,
                                input logic eT, input logic [31:0] eTgt,
                                input logic eMis, input logic [31:0] eRedir,
                                input logic eIll, input logic [31:0] eB,
                                input logic [31:0] eM);
      expect_t e;
      @(posedge clock);
      #1;
      ifPc = lookPc;
      exValid = valid;
      exOpcode = op;
      exFunct3 = f3;
      exPc = pc;
      exRs1 = rs1;
      exRs2 = rs2;
      exImm = imm;
      exPredTaken = pt;
      exPredTarget = ptgt;
      e.name = name;
      e.predTaken = ePt;
      e.predTarget = ePtgt;
      e.taken = eT;
      e.target = eTgt;
      e.mispredict = eMis;
      e.redirect = eRedir;
      e.illegal = eIll;
      e.branchCnt = eB;
      e.mispredCnt = eM;
      expQ.push_back(e);
   endtask

   task automatic lookup(input string name, input logic [31:0] pc, input logic ePt,
                         input logic [31:0] ePtgt, input logic [31:0] eB, input logic [31:0] eM);
      applyStimulus(name, pc, 1'b0, 7'h0, 3'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0,
                    ePt, ePtgt, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, eB, eM);
   endtask

   task automatic resolve(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic pt, input logic [31:0] ptgt,
                          input logic ePt, input logic [31:0] ePtgt,
                          input logic eT, input logic [31:0] eTgt, input logic eMis,
                          input logic [31:0] eRedir, input logic eIll,
                          input logic [31:0] eB, input logic [31:0] eM);
      applyStimulus(name, pc, 1'b1, op, f3, pc, rs1, rs2, imm, pt, ptgt,
                    ePt, ePtgt, eT, eTgt, eMis, eRedir, eIll, eB, eM);
   endtask

   // Monitor: compares every queued expectation on the falling edge
   initial begin
      expect_t e;
      forever begin
         @(negedge clock);
         while (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e.name, "predTaken", 32'(predTaken), 32'(e.predTaken));
            checkOutput(e.name, "predTarget", predTarget, e.predTarget);
            checkOutput(e.name, "exTaken", 32'(exTaken), 32'(e.taken));
            checkOutput(e.name, "exTarget", exTarget, e.target);
            checkOutput(e.name, "mispredict", 32'(mispredict), 32'(e.mispredict));
            checkOutput(e.name, "redirect", redirectPc, e.redirect);
            checkOutput(e.name, "illegal", 32'(illegal), 32'(e.illegal));
            checkOutput(e.name, "branchCnt", branchCnt, e.branchCnt);
            checkOutput(e.name, "mispredCnt", mispredCnt, e.mispredCnt);
         end
      end
   end

   // Directed sequence; expected values hand-computed for ENTRIES=64 (index pc[7:2])
   initial begin
      rstN = 1'b0;
      ifPc = '0; exValid = 1'b0; exOpcode = '0; exFunct3 = '0; exPc = '0;
      exRs1 = '0; exRs2 = '0; exImm = '0; exPredTaken = 1'b0; exPredTarget = '0;
      repeat (2) @(posedge clock);
      #1 rstN = 1'b1;

      lookup("rstLookup", 32'h100, 0, 32'h0, 0, 0);
      resolve("jal", OP_JAL, 3'b000, 32'h100, 0, 0, 32'h40, 0, 0,
              0, 32'h0, 1, 32'h140, 1, 32'h140, 0, 0, 0);
      lookup("jalLookup", 32'h100, 1, 32'h140, 1, 1);

      resolve("beq1", OP_BR, 3'b000, 32'h200, 5, 5, 32'hFFFFFFF8, 0, 0,
              0, 32'h0, 1, 32'h1F8, 1, 32'h1F8, 0, 1, 1);
      lookup("beqLook1", 32'h200, 1, 32'h1F8, 2, 2);
      resolve("beq2", OP_BR, 3'b000, 32'h200, 5, 5, 32'hFFFFFFF8, 1, 32'h1F8,
              1, 32'h1F8, 1, 32'h1F8, 0, 32'h1F8, 0, 2, 2);
      resolve("beq3", OP_BR, 3'b000, 32'h200, 5, 5, 32'hFFFFFFF8, 1, 32'h1F8,
              1, 32'h1F8, 1, 32'h1F8, 0, 32'h1F8, 0, 3, 2);
      resolve("beqNt1", OP_BR, 3'b000, 32'h200, 5, 6, 32'hFFFFFFF8, 1, 32'h1F8,
              1, 32'h1F8, 0, 32'h0, 1, 32'h204, 0, 4, 2);
      lookup("beqLook2", 32'h200, 1, 32'h1F8, 5, 3);
      resolve("beqNt2", OP_BR, 3'b000, 32'h200, 5, 6, 32'hFFFFFFF8, 1, 32'h1F8,
              1, 32'h1F8, 0, 32'h0, 1, 32'h204, 0, 5, 3);
      lookup("beqLook3", 32'h200, 0, 32'h0, 6, 4);

      resolve("blt", OP_BR, 3'b100, 32'h300, 32'hFFFFFFFF, 1, 32'h10, 0, 0,
              0, 32'h0, 1, 32'h310, 1, 32'h310, 0, 6, 4);
      resolve("bltu", OP_BR, 3'b110, 32'h400, 32'hFFFFFFFF, 1, 32'h10, 0, 0,
              0, 32'h0, 0, 32'h0, 0, 32'h404, 0, 7, 5);
      resolve("bgeu", OP_BR, 3'b111, 32'h500, 32'hFFFFFFFF, 1, 32'h20, 0, 0,
              0, 32'h0, 1, 32'h520, 1, 32'h520, 0, 8, 5);
      resolve("jalr", OP_JALR, 3'b000, 32'h600, 32'h1001, 0, 32'h2, 0, 0,
              0, 32'h0, 1, 32'h1002, 1, 32'h1002, 0, 9, 6);
      lookup("jalrLook", 32'h600, 1, 32'h1002, 10, 7);
      resolve("jalrIll", OP_JALR, 3'b001, 32'h700, 32'h1001, 0, 32'h2, 0, 0,
              0, 32'h0, 0, 32'h0, 0, 32'h704, 1, 10, 7);
      lookup("jalrIllLook", 32'h700, 0, 32'h0, 10, 7);

      resolve("bneAlias0", OP_BR, 3'b001, 32'h0, 1, 2, 32'h80, 0, 0,
              0, 32'h0, 1, 32'h80, 1, 32'h80, 0, 10, 7);
      lookup("alias0Look", 32'h0, 1, 32'h80, 11, 8);
      resolve("bgeAlias1", OP_BR, 3'b101, 32'h100, 3, 3, 32'h40, 0, 0,
              0, 32'h0, 1, 32'h140, 1, 32'h140, 0, 11, 8);
      lookup("alias0Miss", 32'h0, 0, 32'h0, 12, 9);
      lookup("alias1Hit", 32'h100, 1, 32'h140, 12, 9);
      resolve("scrub", OP_ALU, 3'b000, 32'h100, 0, 0, 0, 1, 32'h140,
              1, 32'h140, 0, 32'h0, 1, 32'h104, 0, 12, 9);
      lookup("scrubLook", 32'h100, 0, 32'h0, 12, 10);
      resolve("brIll", OP_BR, 3'b010, 32'h800, 0, 0, 32'h10, 0, 0,
              0, 32'h0, 0, 32'h0, 0, 32'h804, 1, 12, 10);
      lookup("cntLook", 32'h200, 0, 32'h0, 12, 10);

      @(posedge clock);
      #1 rstN = 1'b0;
      lookup("midReset", 32'h600, 0, 32'h0, 0, 0);
      @(posedge clock);
      #1 rstN = 1'b1;
      lookup("postReset", 32'h100, 0, 32'h0, 0, 0);
      resolve("jalOk", OP_JAL, 3'b000, 32'h100, 0, 0, 32'h40, 1, 32'h140,
              0, 32'h0, 1, 32'h140, 0, 32'h140, 0, 0, 0);
      resolve("jalBadTgt", OP_JAL, 3'b000, 32'h100, 0, 0, 32'h40, 1, 32'h144,
              1, 32'h140, 1, 32'h140, 1, 32'h140, 0, 1, 0);
      lookup("finalLook", 32'h100, 1, 32'h140, 2, 1);

      for (int i = 0; i < 10 && expQ.size() > 0; i++) begin
         @(negedge clock);
         #1;
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
